// File: rtl/pixel_serializer_pkg.sv
// Shared constants and types for the pixel serializer: default glyph geometry,
// the shifter state encoding and a counter-width helper.
package pixel_serializer_pkg;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_PIX_REP = 1;

  // The shifter is either waiting for a byte or holding one that is being shifted.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  // Counter width for a 0..n-1 counter, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_serializer_if.sv
// Glyph byte handshake between the character fetch path and the serializer.
//
// Handshake: the source drives data_in/data_valid, the serializer drives en_nxt
// (ready). A byte transfers on every rising edge where data_valid && en_nxt.
// en_nxt does not depend on data_valid, and the source may raise or drop
// data_valid freely; data_in is only sampled on a transfer edge.
interface pixel_serializer_if #(
  parameter int WIDTH = pixel_serializer_pkg::DEFAULT_WIDTH
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             en_nxt;

  modport master (output data_in, output data_valid, input en_nxt);
  modport slave  (input data_in, input data_valid, output en_nxt);
endinterface

// File: rtl/pixel_serializer_pix_shift_reg.sv
// Shift datapath: the glyph byte being displayed, its bit counter and the
// horizontal-zoom repeat counter. Shifts MSB-first, one bit per PIX_REP enables.
module pixel_serializer_pix_shift_reg
  import pixel_serializer_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int PIX_REP = DEFAULT_PIX_REP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             enable,
  output logic             msb,
  output logic             last
);

  localparam int CW = cnt_width(WIDTH);
  localparam int RW = cnt_width(PIX_REP);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(PIX_REP - 1);

  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bitcnt;
  logic [RW-1:0]    repcnt;

  // Clear beats load beats shift; counters return to zero explicitly at their ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      bitcnt <= '0;
      repcnt <= '0;
    end else if (clear) begin
      bitcnt <= '0;
      repcnt <= '0;
    end else if (load) begin
      shreg  <= load_data;
      bitcnt <= '0;
      repcnt <= '0;
    end else if (enable) begin
      if (repcnt == REP_LAST) begin
        repcnt <= '0;
        shreg  <= {shreg[WIDTH-2:0], 1'b0};
        bitcnt <= (bitcnt == BIT_LAST) ? '0 : bitcnt + CW'(1);
      end else begin
        repcnt <= repcnt + RW'(1);
      end
    end
  end

  assign msb  = shreg[WIDTH-1];
  assign last = (bitcnt == BIT_LAST) && (repcnt == REP_LAST);

endmodule

// File: rtl/pixel_serializer.sv
// Glyph-row serializer: a holding register in front of a shift register turns
// fetched glyph bytes into a one-bit pixel stream for the RGB stage. Shifting
// advances only in the visible area; line_start flushes everything.
module pixel_serializer
  import pixel_serializer_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int PIX_REP = DEFAULT_PIX_REP
) (
  input  logic                vga_clk,
  input  logic                reset,
  input  logic                display_area,
  input  logic                line_start,
  pixel_serializer_if.slave   pix,
  output logic                serial_output,
  output logic                underrun,
  output ser_state_e          dbg_state
);

  ser_state_e       state;
  ser_state_e       state_nxt;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic             underrun_q;
  logic             accept;
  logic             load;
  logic             take;
  logic             shift_en;
  logic             sh_msb;
  logic             sh_last;

  assign pix.en_nxt = !hold_full;
  assign accept     = pix.data_valid && !hold_full;

  // Shifter state register (state == ST_SHIFT is the shreg-full flag).
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  // Next state plus load/shift strobes; line_start suppresses all shifter activity.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    take      = 1'b0;
    shift_en  = 1'b0;
    if (line_start) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (hold_full) begin
            load      = 1'b1;
            take      = 1'b1;
            state_nxt = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (display_area) begin
            if (sh_last && hold_full) begin
              // Seamless reload: the next byte's MSB follows with no gap pixel.
              load = 1'b1;
              take = 1'b1;
            end else begin
              shift_en = 1'b1;
              if (sh_last) state_nxt = ST_EMPTY;
            end
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Holding register: written on accept, emptied by a transfer or a line flush.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      if (accept) hold <= pix.data_in;
      if (line_start) hold_full <= accept;
      else            hold_full <= accept || (hold_full && !take);
    end
  end

  // Sticky underrun: visible pixel requested while the shifter was empty.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset)                                  underrun_q <= 1'b0;
    else if (line_start)                         underrun_q <= 1'b0;
    else if (display_area && state == ST_EMPTY)  underrun_q <= 1'b1;
  end

  pixel_serializer_pix_shift_reg #(
    .WIDTH  (WIDTH),
    .PIX_REP(PIX_REP)
  ) u_shift (
    .clk      (vga_clk),
    .rst_n    (reset),
    .clear    (line_start),
    .load     (load),
    .load_data(hold),
    .enable   (shift_en),
    .msb      (sh_msb),
    .last     (sh_last)
  );

  assign serial_output = (state == ST_SHIFT) && sh_msb;
  assign underrun      = underrun_q;
  assign dbg_state     = state;

endmodule
